// File: rtl/lcd_write_engine.sv
// Byte-wide HD44780 write engine: one byte per valid/ready handshake, 4-bit (two nibbles) or 8-bit bus.
// Latency: RS/DB driven the cycle after acceptance, E after SETUP_CYC; done pulses the cycle after the post-wait.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while busy and there is no queueing.
module lcd_write_engine #(
    parameter int SETUP_CYC      = 2,
    parameter int E_HIGH_CYC     = 12,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int LONG_WAIT_CYC  = 82000,
    parameter int CNT_W          = 17,
    parameter int BUS_8BIT       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] DB
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP_HI = 3'd1;
    localparam logic [2:0] S_PULSE_HI = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_SETUP_LO = 3'd4;
    localparam logic [2:0] S_PULSE_LO = 3'd5;
    localparam logic [2:0] S_WAIT     = 3'd6;

    // Terminal count of each timed state (delay - 1).
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(NIBBLE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic [3:0]       lo_q;
    logic             long_q;
    logic             accept;
    logic             last;

    assign in_ready = (state == S_IDLE) & reset;
    assign accept   = in_valid & in_ready;
    assign last     = (cnt == cnt_last);

    // Select the terminal count for the state currently being timed.
    always_comb begin
        cnt_last = '0;
        case (state)
            S_SETUP_HI, S_SETUP_LO: cnt_last = SETUP_LAST;
            S_PULSE_HI, S_PULSE_LO: cnt_last = E_LAST;
            S_GAP:                  cnt_last = GAP_LAST;
            S_WAIT:                 cnt_last = long_q ? LONG_LAST : CMD_LAST;
            default:                cnt_last = '0;
        endcase
    end

    // Next-state sequencing; 8-bit mode skips the lower-nibble states entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_SETUP_HI;
            S_SETUP_HI: if (last)   state_nxt = S_PULSE_HI;
            S_PULSE_HI: if (last)   state_nxt = (BUS_8BIT != 0) ? S_WAIT : S_GAP;
            S_GAP:      if (last)   state_nxt = S_SETUP_LO;
            S_SETUP_LO: if (last)   state_nxt = S_PULSE_LO;
            S_PULSE_LO: if (last)   state_nxt = S_WAIT;
            S_WAIT:     if (last)   state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // State, delay counter and registered LCD pins; pins only move on state transitions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            lo_q   <= 4'h0;
            long_q <= 1'b0;
            LCD_E  <= 1'b0;
            LCD_RS <= 1'b0;
            LCD_RW <= 1'b0;
            DB     <= 8'h00;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            LCD_RW <= 1'b0;
            done   <= 1'b0;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state != S_IDLE) begin
                cnt <= cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lo_q   <= in_data[3:0];
                        // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
                        long_q <= ~in_rs & (in_data[7:2] == 6'd0);
                        LCD_RS <= in_rs;
                        DB     <= (BUS_8BIT != 0) ? in_data : {in_data[7:4], 4'h0};
                    end
                end
                S_SETUP_HI, S_SETUP_LO: begin
                    if (last) LCD_E <= 1'b1;
                end
                S_PULSE_HI, S_PULSE_LO: begin
                    if (last) LCD_E <= 1'b0;
                end
                S_GAP: begin
                    // Upper nibble is held through the gap for hold time, swapped only at its end.
                    if (last) DB <= {lo_q, 4'h0};
                end
                S_WAIT: begin
                    if (last) begin
                        done   <= 1'b1;
                        LCD_RS <= 1'b0;
                        DB     <= 8'h00;
                    end
                end
                default: begin
                    LCD_E <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine: 4-bit and 8-bit instances with shortened waits.
// Latency: expected per-cycle pin traces are built from the timing rules with hand-computed occupancies.
// Backpressure: covers held in_valid, back-to-back handshakes on the done cycle and mid-pulse reset.
module tb_lcd_write_engine;

    // Shortened timing so long waits stay within a small cycle budget.
    localparam int S = 2;
    localparam int H = 12;
    localparam int G = 50;
    localparam int W = 100;
    localparam int L = 400;
    // 4-bit occupancy 2*2 + 2*12 + 50 + wait; 8-bit occupancy 2 + 12 + wait.
    localparam int OCC4_N = 178;
    localparam int OCC4_L = 478;
    localparam int OCC8_N = 114;
    localparam int OCC8_L = 414;

    logic       clk;
    logic       reset;
    logic       v4, rs4_i, v8, rs8_i;
    logic [7:0] d4, d8;
    logic       rdy4, done4, e4, rs4, rw4;
    logic       rdy8, done8, e8, rs8, rw8;
    logic [7:0] db4, db8;

    int n_cmp;
    int n_bad;

    logic       e_tr    [0:1023];
    logic       rs_tr   [0:1023];
    logic       rw_tr   [0:1023];
    logic       done_tr [0:1023];
    logic       rdy_tr  [0:1023];
    logic [7:0] db_tr   [0:1023];

    lcd_write_engine #(
        .SETUP_CYC(S), .E_HIGH_CYC(H), .NIBBLE_GAP_CYC(G),
        .CMD_WAIT_CYC(W), .LONG_WAIT_CYC(L), .CNT_W(10), .BUS_8BIT(0)
    ) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_rs(rs4_i), .in_data(d4),
        .in_ready(rdy4), .done(done4), .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .DB(db4)
    );

    lcd_write_engine #(
        .SETUP_CYC(S), .E_HIGH_CYC(H), .NIBBLE_GAP_CYC(G),
        .CMD_WAIT_CYC(W), .LONG_WAIT_CYC(L), .CNT_W(10), .BUS_8BIT(1)
    ) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_rs(rs8_i), .in_data(d8),
        .in_ready(rdy8), .done(done8), .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .DB(db8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and wait (bounded) for the handshake edge; leaves time at index 1.
    task automatic start(input bit b8, input logic rs, input logic [7:0] data, input bit hold);
        int w;
        w = 0;
        if (b8) begin v8 = 1'b1; rs8_i = rs; d8 = data; end
        else    begin v4 = 1'b1; rs4_i = rs; d4 = data; end
        while (!(b8 ? rdy8 : rdy4) && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("accept_ready", {31'd0, (b8 ? rdy8 : rdy4)}, 32'd1);
        @(posedge clk); #1;
        if (!hold) begin v4 = 1'b0; v8 = 1'b0; end
    endtask

    // Record pins for indices 1..n (index i = i-th cycle after the acceptance edge).
    task automatic capture(input bit b8, input int n, input bit chg, input logic [7:0] alt);
        for (int i = 1; i <= n; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            if (chg && i == 3) d4 = alt;
            if (b8) begin
                e_tr[i] = e8; rs_tr[i] = rs8; rw_tr[i] = rw8;
                done_tr[i] = done8; rdy_tr[i] = rdy8; db_tr[i] = db8;
            end else begin
                e_tr[i] = e4; rs_tr[i] = rs4; rw_tr[i] = rw4;
                done_tr[i] = done4; rdy_tr[i] = rdy4; db_tr[i] = db4;
            end
        end
    endtask

    // Compare the captured trace against the expected waveform of one transaction.
    task automatic verify(input string tag, input bit b8, input logic rs, input logic [7:0] data,
                          input int occ, input int n);
        int be, bd, br, bw, bdn, bry, first_done, ecnt;
        logic       xe;
        logic [7:0] xdb;
        be = 0; bd = 0; br = 0; bw = 0; bdn = 0; bry = 0; first_done = 0; ecnt = 0;
        for (int i = 1; i <= n; i++) begin
            xe = (i > S && i <= S + H) ||
                 (!b8 && i > 2 * S + H + G && i <= 2 * S + 2 * H + G);
            if (i > occ)              xdb = 8'h00;
            else if (b8)              xdb = data;
            else if (i <= S + H + G)  xdb = {data[7:4], 4'h0};
            else                      xdb = {data[3:0], 4'h0};
            if (e_tr[i] !== xe) be++;
            if (db_tr[i] !== xdb) bd++;
            if (rs_tr[i] !== ((i <= occ) ? rs : 1'b0)) br++;
            if (rw_tr[i] !== 1'b0) bw++;
            if (done_tr[i] !== (i == occ + 1)) bdn++;
            if (rdy_tr[i] !== (i > occ)) bry++;
            if (done_tr[i] === 1'b1 && first_done == 0) first_done = i;
            if (e_tr[i] === 1'b1) ecnt++;
        end
        chk({tag, "_e_bad"},    be, 0);
        chk({tag, "_db_bad"},   bd, 0);
        chk({tag, "_rs_bad"},   br, 0);
        chk({tag, "_rw_bad"},   bw, 0);
        chk({tag, "_done_bad"}, bdn, 0);
        chk({tag, "_rdy_bad"},  bry, 0);
        chk({tag, "_done_at"},  first_done, occ + 1);
        chk({tag, "_e_cycles"}, ecnt, b8 ? H : 2 * H);
    endtask

    initial begin
        int ecnt, dcnt, rcnt;
        clk = 1'b0; reset = 1'b0;
        v4 = 1'b0; rs4_i = 1'b0; d4 = 8'h00;
        v8 = 1'b0; rs8_i = 1'b0; d8 = 8'h00;
        n_cmp = 0; n_bad = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_e",    {31'd0, e4},    0);
        chk("rst_rs",   {31'd0, rs4},   0);
        chk("rst_rw",   {31'd0, rw4},   0);
        chk("rst_db",   {24'd0, db4},   0);
        chk("rst_done", {31'd0, done4}, 0);
        chk("rst_rdy4", {31'd0, rdy4},  0);
        chk("rst_rdy8", {31'd0, rdy8},  0);
        reset = 1'b1;
        #1;
        chk("rel_rdy4", {31'd0, rdy4}, 1);
        chk("rel_rdy8", {31'd0, rdy8}, 1);
        @(posedge clk); #1;

        // Data write 0x41: nibbles 0x4 then 0x1, normal wait.
        start(1'b0, 1'b1, 8'h41, 1'b0);
        capture(1'b0, OCC4_N + 2, 1'b0, 8'h00);
        verify("w41", 1'b0, 1'b1, 8'h41, OCC4_N, OCC4_N + 2);

        // Clear display: long wait.
        start(1'b0, 1'b0, 8'h01, 1'b0);
        capture(1'b0, OCC4_L + 2, 1'b0, 8'h00);
        verify("c01", 1'b0, 1'b0, 8'h01, OCC4_L, OCC4_L + 2);

        // Function set 0x28: normal wait.
        start(1'b0, 1'b0, 8'h28, 1'b0);
        capture(1'b0, OCC4_N + 2, 1'b0, 8'h00);
        verify("c28", 1'b0, 1'b0, 8'h28, OCC4_N, OCC4_N + 2);

        // 0x04 is the first command above the long-wait range.
        start(1'b0, 1'b0, 8'h04, 1'b0);
        capture(1'b0, OCC4_N + 2, 1'b0, 8'h00);
        verify("c04", 1'b0, 1'b0, 8'h04, OCC4_N, OCC4_N + 2);

        // Data byte 0x01 must not get the long wait.
        start(1'b0, 1'b1, 8'h01, 1'b0);
        capture(1'b0, OCC4_N + 2, 1'b0, 8'h00);
        verify("d01", 1'b0, 1'b1, 8'h01, OCC4_N, OCC4_N + 2);

        // 8-bit bus: single pulse, normal and long.
        start(1'b1, 1'b1, 8'hA5, 1'b0);
        capture(1'b1, OCC8_N + 2, 1'b0, 8'h00);
        verify("b8_a5", 1'b1, 1'b1, 8'hA5, OCC8_N, OCC8_N + 2);

        start(1'b1, 1'b0, 8'h02, 1'b0);
        capture(1'b1, OCC8_L + 2, 1'b0, 8'h00);
        verify("b8_c02", 1'b1, 1'b0, 8'h02, OCC8_L, OCC8_L + 2);

        // Held in_valid, data changed while busy, second handshake on the done cycle.
        start(1'b0, 1'b1, 8'h5A, 1'b1);
        capture(1'b0, OCC4_N + 1, 1'b1, 8'hC3);
        verify("b2b_1", 1'b0, 1'b1, 8'h5A, OCC4_N, OCC4_N + 1);
        @(posedge clk); #1;
        v4 = 1'b0;
        capture(1'b0, OCC4_N + 2, 1'b0, 8'h00);
        verify("b2b_2", 1'b0, 1'b1, 8'hC3, OCC4_N, OCC4_N + 2);

        // Reset in the middle of the lower-nibble pulse.
        start(1'b0, 1'b1, 8'h41, 1'b0);
        capture(1'b0, 2 * S + H + G + 3, 1'b0, 8'h00);
        chk("pre_rst_e", {31'd0, e_tr[2 * S + H + G + 3]}, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_e",    {31'd0, e4},    0);
        chk("mid_rst_rs",   {31'd0, rs4},   0);
        chk("mid_rst_db",   {24'd0, db4},   0);
        chk("mid_rst_done", {31'd0, done4}, 0);
        chk("mid_rst_rdy",  {31'd0, rdy4},  0);
        reset = 1'b1;
        #1;
        chk("post_rst_rdy", {31'd0, rdy4}, 1);
        ecnt = 0; dcnt = 0; rcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (e4 === 1'b1) ecnt++;
            if (done4 === 1'b1) dcnt++;
            if (rdy4 === 1'b1) rcnt++;
        end
        chk("post_rst_e_cycles", ecnt, 0);
        chk("post_rst_done",     dcnt, 0);
        chk("post_rst_rdy_cyc",  rcnt, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
